// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, compare codes and unit indices shared by the ALU.
package alu_pkg;
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_NAND  = 4'h6;
    localparam logic [3:0] OP_NOR   = 4'h7;
    localparam logic [3:0] OP_NOP   = 4'h8;
    localparam logic [3:0] OP_EQ    = 4'h9;
    localparam logic [3:0] OP_GT    = 4'hA;
    localparam logic [3:0] OP_LT    = 4'hB;
    localparam logic [3:0] OP_SHR_A = 4'hC;
    localparam logic [3:0] OP_SHL_A = 4'hD;
    localparam logic [3:0] OP_SHR_B = 4'hE;
    localparam logic [3:0] OP_SHL_B = 4'hF;
    localparam logic [1:0] CMP_NOP = 2'd0;
    localparam logic [1:0] CMP_EQ  = 2'd1;
    localparam logic [1:0] CMP_GT  = 2'd2;
    localparam logic [1:0] CMP_LT  = 2'd3;
    typedef enum logic [1:0] {U_ARITH, U_LOGIC, U_CMP, U_SHIFT} unit_e;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the opcode's unit field to one-hot unit enables.
module alu_decoder (
    input  logic [1:0] sel,
    output logic [3:0] en
);
    always_comb en = 4'b0001 << sel;
endmodule

// File: rtl/alu_top.sv
// alu_top: registered signed ALU with arithmetic, logic, compare and shift units.
// Define ALU_DIV_EN to build the signed divider for opcode 0011.
module alu_top
    import alu_pkg::*;
#(
    parameter int width       = 16,
    parameter int Arith_width = 2 * width,
    parameter int Logic_width = width,
    parameter int CMP_width   = width,
    parameter int Shift_width = width
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [width-1:0]       A,
    input  logic [width-1:0]       B,
    input  logic [3:0]             ALU_FUN,
    output logic [Arith_width-1:0] Arith_OUT,
    output logic                   Carry_OUT,
    output logic                   Arith_Flag,
    output logic [Logic_width-1:0] Logic_OUT,
    output logic                   Logic_Flag,
    output logic [CMP_width-1:0]   CMP_OUT,
    output logic                   CMP_Flag,
    output logic [Shift_width-1:0] Shift_OUT,
    output logic                   Shift_Flag
);
    logic [3:0] en;
    logic signed [Arith_width-1:0] a_ext, b_ext, div_q, arith_d;
    logic [width:0] add_u, sub_u;
    logic [Logic_width-1:0] logic_d;
    logic [CMP_width-1:0] cmp_d;
    logic [Shift_width-1:0] shift_d;
    logic carry_d;

    alu_decoder u_dec (.sel(ALU_FUN[3:2]), .en(en));

    // operands widened once so the product and the -min/-1 quotient fit
    assign a_ext = Arith_width'($signed(A));
    assign b_ext = Arith_width'($signed(B));
    assign add_u = {1'b0, A} + {1'b0, B};
    assign sub_u = {1'b0, A} + {1'b0, ~B} + (width + 1)'(1);
`ifdef ALU_DIV_EN
    assign div_q = (B == '0) ? '0 : a_ext / b_ext;
`else
    assign div_q = '0;
`endif

    always_comb begin
        arith_d = !en[U_ARITH]      ? '0 :
                  ALU_FUN == OP_ADD ? a_ext + b_ext :
                  ALU_FUN == OP_SUB ? a_ext - b_ext :
                  ALU_FUN == OP_MUL ? a_ext * b_ext : div_q;
        carry_d = en[U_ARITH] && ALU_FUN == OP_ADD ? add_u[width] :
                  en[U_ARITH] && ALU_FUN == OP_SUB ? sub_u[width] : 1'b0;
    end

    always_comb
        logic_d = !en[U_LOGIC]       ? '0 :
                  ALU_FUN == OP_AND  ? Logic_width'(A & B) :
                  ALU_FUN == OP_OR   ? Logic_width'(A | B) :
                  ALU_FUN == OP_NAND ? Logic_width'(~(A & B)) : Logic_width'(~(A | B));

    always_comb
        cmp_d = !en[U_CMP]                                  ? '0 :
                ALU_FUN == OP_EQ && A == B                  ? CMP_width'(CMP_EQ) :
                ALU_FUN == OP_GT && $signed(A) > $signed(B) ? CMP_width'(CMP_GT) :
                ALU_FUN == OP_LT && $signed(A) < $signed(B) ? CMP_width'(CMP_LT) :
                CMP_width'(CMP_NOP);

    always_comb
        shift_d = !en[U_SHIFT]         ? '0 :
                  ALU_FUN == OP_SHR_A  ? Shift_width'(A >> 1) :
                  ALU_FUN == OP_SHL_A  ? Shift_width'(A << 1) :
                  ALU_FUN == OP_SHR_B  ? Shift_width'(B >> 1) : Shift_width'(B << 1);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            Arith_OUT  <= '0;
            Carry_OUT  <= 1'b0;
            Arith_Flag <= 1'b0;
            Logic_OUT  <= '0;
            Logic_Flag <= 1'b0;
            CMP_OUT    <= '0;
            CMP_Flag   <= 1'b0;
            Shift_OUT  <= '0;
            Shift_Flag <= 1'b0;
        end else begin
            Arith_OUT  <= arith_d;
            Carry_OUT  <= carry_d;
            Arith_Flag <= en[U_ARITH];
            Logic_OUT  <= logic_d;
            Logic_Flag <= en[U_LOGIC];
            CMP_OUT    <= cmp_d;
            CMP_Flag   <= en[U_CMP];
            Shift_OUT  <= shift_d;
            Shift_Flag <= en[U_SHIFT];
        end
    end
endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: scoreboard bench for alu_top; honours ALU_DIV_EN for the divide vectors.
module tb_alu_top;
    typedef struct packed {
        logic [31:0] arith;
        logic        carry;
        logic [3:0]  flags;
        logic [15:0] lo;
        logic [15:0] cmp;
        logic [15:0] sh;
    } res_t;

    logic CLK = 1'b0, RST = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic [3:0] ALU_FUN = '0;
    logic [31:0] Arith_OUT;
    logic [15:0] Logic_OUT, CMP_OUT, Shift_OUT;
    logic Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;

    res_t exp_q[$];
    string name_q[$];
    int total = 0, bad = 0;

    alu_top dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
        .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag)
    );

    always #5 CLK = ~CLK;

    function automatic res_t ar(input logic [31:0] v, input logic c);
        return '{arith: v, carry: c, flags: 4'b0001, lo: '0, cmp: '0, sh: '0};
    endfunction
    function automatic res_t lg(input logic [15:0] v);
        return '{arith: '0, carry: 1'b0, flags: 4'b0010, lo: v, cmp: '0, sh: '0};
    endfunction
    function automatic res_t cm(input logic [15:0] v);
        return '{arith: '0, carry: 1'b0, flags: 4'b0100, lo: '0, cmp: v, sh: '0};
    endfunction
    function automatic res_t sh(input logic [15:0] v);
        return '{arith: '0, carry: 1'b0, flags: 4'b1000, lo: '0, cmp: '0, sh: v};
    endfunction

    task automatic vec(input string nm, input logic r, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b, input res_t e);
        @(negedge CLK);
        RST = r; ALU_FUN = op; A = a; B = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // monitor: every edge with an outstanding stimulus yields one registered result
    initial forever begin
        @(posedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            res_t e, got;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            got = '{arith: Arith_OUT, carry: Carry_OUT,
                    flags: {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag},
                    lo: Logic_OUT, cmp: CMP_OUT, sh: Shift_OUT};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got arith=%h c=%b fl=%b lo=%h cmp=%h sh=%h want arith=%h c=%b fl=%b lo=%h cmp=%h sh=%h",
                         nm, got.arith, got.carry, got.flags, got.lo, got.cmp, got.sh,
                         e.arith, e.carry, e.flags, e.lo, e.cmp, e.sh);
            end
        end
    end

    initial begin
        res_t zero, div_a, div_b, div_min;
        zero = '0;
`ifdef ALU_DIV_EN
        div_a = ar(32'hFFFF_FFFE, 1'b0);
        div_min = ar(32'h0000_8000, 1'b0);
`else
        div_a = ar(32'h0, 1'b0);
        div_min = ar(32'h0, 1'b0);
`endif
        div_b = ar(32'h0, 1'b0);
        vec("reset",      1'b0, 4'h0, 16'd5, 16'd10, zero);
        vec("add_neg",    1'b1, 4'h0, 16'hFFFB, 16'hFFF6, ar(32'hFFFF_FFF1, 1'b1));
        vec("add_pos",    1'b1, 4'h0, 16'd5, 16'd10, ar(32'd15, 1'b0));
        vec("sub_pos",    1'b1, 4'h1, 16'd5, 16'hFFF6, ar(32'd15, 1'b0));
        vec("sub_neg",    1'b1, 4'h1, 16'hFFFB, 16'd10, ar(32'hFFFF_FFF1, 1'b1));
        vec("sub_eq",     1'b1, 4'h1, 16'd10, 16'd10, ar(32'd0, 1'b1));
        vec("mul_nn",     1'b1, 4'h2, 16'hFFFB, 16'hFFF6, ar(32'd50, 1'b0));
        vec("mul_pn",     1'b1, 4'h2, 16'd5, 16'hFFF6, ar(32'hFFFF_FFCE, 1'b0));
        vec("mul_min",    1'b1, 4'h2, 16'h8000, 16'h8000, ar(32'h4000_0000, 1'b0));
        vec("div",        1'b1, 4'h3, 16'hFFF6, 16'd5, div_a);
        vec("div_zero",   1'b1, 4'h3, 16'd7, 16'd0, div_b);
        vec("div_min",    1'b1, 4'h3, 16'h8000, 16'hFFFF, div_min);
        vec("and",        1'b1, 4'h4, 16'h00D9, 16'h00B2, lg(16'h0090));
        vec("or",         1'b1, 4'h5, 16'h00D9, 16'h00B2, lg(16'h00FB));
        vec("nand",       1'b1, 4'h6, 16'h00D9, 16'h00B2, lg(16'hFF6F));
        vec("nor",        1'b1, 4'h7, 16'h00D9, 16'h00B2, lg(16'hFF04));
        vec("cmp_nop",    1'b1, 4'h8, 16'd10, 16'd10, cm(16'd0));
        vec("cmp_eq",     1'b1, 4'h9, 16'd10, 16'd10, cm(16'd1));
        vec("cmp_gt",     1'b1, 4'hA, 16'd10, 16'd4, cm(16'd2));
        vec("cmp_lt",     1'b1, 4'hB, 16'd4, 16'd10, cm(16'd3));
        vec("cmp_gt_no",  1'b1, 4'hA, 16'd4, 16'd10, cm(16'd0));
        vec("cmp_gt_sgn", 1'b1, 4'hA, 16'hFFFF, 16'd1, cm(16'd0));
        vec("cmp_lt_sgn", 1'b1, 4'hB, 16'hFFFF, 16'd1, cm(16'd3));
        vec("shr_a",      1'b1, 4'hC, 16'd10, 16'd0, sh(16'd5));
        vec("shl_a",      1'b1, 4'hD, 16'd6, 16'd0, sh(16'd12));
        vec("shr_b",      1'b1, 4'hE, 16'd0, 16'd4, sh(16'd2));
        vec("shl_b",      1'b1, 4'hF, 16'd0, 16'd7, sh(16'd14));
        vec("shr_a_msb",  1'b1, 4'hC, 16'h8000, 16'd0, sh(16'h4000));
        vec("shl_b_msb",  1'b1, 4'hF, 16'd0, 16'h8001, sh(16'h0002));
        vec("mid_reset",  1'b0, 4'h0, 16'hFFFB, 16'hFFF6, zero);
        vec("post_reset", 1'b1, 4'h4, 16'h00D9, 16'h00B2, lg(16'h0090));
        vec("back_to_add",1'b1, 4'h0, 16'd5, 16'd10, ar(32'd15, 1'b0));
        repeat (3) @(posedge CLK);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
